// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC arbiter: FSM encoding, widths, quiet-NaN fill word.
package cordic_pkg;

  localparam int FLOAT_DATA_WIDTH = 32;
  localparam int COUNTER_WIDTH    = 10;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_ISSUE   = 2'd1;
  localparam arb_state_t ST_WAIT    = 2'd2;
  localparam arb_state_t ST_RESPOND = 2'd3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/rr_priority_pick.sv
// Cyclic first-set search: picks the lowest set bit of req at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  always_comb begin
    // rot[k] is requester (ptr + k) mod NUM_REQ
    rot     = NUM_REQ'({req, req} >> ptr);
    any_req = |req;
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = ID_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
    grant_id = sum[ID_W-1:0];
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one CORDIC core among NUM_REQ requesters.
// Optional core-done watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
  parameter int FLOAT_DATA_WIDTH = cordic_pkg::FLOAT_DATA_WIDTH,
  parameter int NUM_REQ          = 4,
  parameter int REQ_ID_WIDTH     = 2,
  parameter int COUNTER_WIDTH    = cordic_pkg::COUNTER_WIDTH,
  parameter int TIMEOUT_CYCLES   = 1000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_angle,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [FLOAT_DATA_WIDTH-1:0]         resp_result,
  output logic                                resp_error,
  output logic                                busy,
  output logic                                core_clk_en,
  output logic [FLOAT_DATA_WIDTH-1:0]         core_angle,
  input  logic [FLOAT_DATA_WIDTH-1:0]         core_result,
  input  logic                                core_done
);

  import cordic_pkg::*;

  arb_state_t              state;
  logic [REQ_ID_WIDTH-1:0] rr_ptr;
  logic [REQ_ID_WIDTH-1:0] grant_id;
  logic [REQ_ID_WIDTH-1:0] pick_id;
  logic                    any_req;
  logic                    timeout;

  logic [FLOAT_DATA_WIDTH-1:0] angle_arr [NUM_REQ];
  logic [NUM_REQ-1:0]          resp_hot;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign angle_arr[i] = req_angle[i*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH];
    assign resp_hot[i]  = (grant_id == REQ_ID_WIDTH'(i));
  end

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (REQ_ID_WIDTH)
  ) u_pick (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant_id (pick_id),
    .any_req  (any_req)
  );

  function automatic logic [REQ_ID_WIDTH-1:0] next_ptr(input logic [REQ_ID_WIDTH-1:0] id);
    if (id == REQ_ID_WIDTH'(NUM_REQ - 1)) return '0;
    return id + 1'b1;
  endfunction

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam logic [COUNTER_WIDTH-1:0] TO_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNTER_WIDTH-1:0] wait_cnt;

  // wait_cnt counts WAIT cycles already spent; the last allowed one trips timeout
  assign timeout = (state == ST_WAIT) && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= '0;
    else if (state == ST_ISSUE) wait_cnt <= '0;
    else if (state == ST_WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_error  <= 1'b0;
      busy        <= 1'b0;
      core_clk_en <= 1'b0;
      core_angle  <= '0;
    end else begin
      core_clk_en <= 1'b0;
      resp_valid  <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_id    <= pick_id;
            core_angle  <= angle_arr[pick_id];
            busy        <= 1'b1;
            core_clk_en <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          // done beats a coincident timeout
          if (core_done) begin
            resp_result <= core_result;
            resp_error  <= 1'b0;
            resp_valid  <= resp_hot;
            state       <= ST_RESPOND;
          end else if (timeout) begin
            resp_result <= FLOAT_DATA_WIDTH'(QNAN);
            resp_error  <= 1'b1;
            resp_valid  <= resp_hot;
            state       <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          rr_ptr <= next_ptr(grant_id);
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: transaction-level round-robin model plus a CORDIC core stand-in.
`timescale 1ns/1ps
module tb_cordic_arbiter;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 20;
  localparam logic [W-1:0] QNAN_EXP = 32'h7FC0_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_angle;
  logic [N-1:0]     resp_valid;
  logic [W-1:0]     resp_result;
  logic             resp_error;
  logic             busy;
  logic             core_clk_en;
  logic [W-1:0]     core_angle;
  logic [W-1:0]     core_result;
  logic             core_done;

  cordic_arbiter #(
    .FLOAT_DATA_WIDTH (W),
    .NUM_REQ          (N),
    .REQ_ID_WIDTH     (IDW),
    .COUNTER_WIDTH    (10),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_angle   (req_angle),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_error  (resp_error),
    .busy        (busy),
    .core_clk_en (core_clk_en),
    .core_angle  (core_angle),
    .core_result (core_result),
    .core_done   (core_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   res;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mdl_ptr = 0;
  int   phase_t0 = 0;
  int   resp_seen = 0;
  int   last_resp_cyc = 0;
  int   core_lat = 12;
  bit   core_hang = 1'b0;
  int   core_starts = 0;

  logic [W-1:0] drv_ang [N][8];
  int           drv_n [N];
  int           drv_i [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] core_fn(input logic [W-1:0] a);
    if (a == 32'h3F80_0000) return 32'h3F57_6AA4;
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  // CORDIC stand-in: done pulses core_lat cycles after the start pulse
  initial begin : core_model
    int cnt;
    bit act;
    bit prev_en;
    logic [W-1:0] ang;
    cnt = 0; act = 1'b0; prev_en = 1'b0; ang = '0;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (act) begin
        cnt--;
        if (cnt == 0) begin
          act = 1'b0;
          if (busy) check("core_angle_stable", core_angle, ang);
          core_done = 1'b1;
          core_result = core_fn(ang);
        end
      end
      if (core_clk_en) begin
        check("start_single_cycle", prev_en, 0);
        core_starts++;
        ang = core_angle;
        cnt = core_lat;
        act = !core_hang;
      end
      prev_en = core_clk_en;
    end
  end

  // requesters hold until served, then present their next angle or drop
  initial begin : requesters
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (resp_valid[i] && req_valid[i]) begin
          drv_i[i]++;
          if (drv_i[i] < drv_n[i]) req_angle[i*W +: W] = drv_ang[i][drv_i[i]];
          else req_valid[i] = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    logic [N-1:0] hot;
    forever begin
      @(negedge clk);
      if (|resp_valid) begin
        resp_seen++;
        last_resp_cyc = cyc;
        check("resp_onehot", 64'($onehot(resp_valid)), 1);
        if (sb.size() == 0) begin
          check("resp_unexpected", resp_valid, 0);
        end else begin
          e = sb.pop_front();
          hot = '0;
          hot[e.id] = 1'b1;
          check("resp_id", resp_valid, hot);
          check("resp_result", resp_result, e.res);
          check("resp_error", resp_error, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic clear_drv();
    for (int i = 0; i < N; i++) begin
      drv_n[i] = 0;
      drv_i[i] = 0;
    end
  endtask

  // Predict the service order from the requests' angle lists, then launch and wait.
  task automatic run_phase(input int lat, input bit expect_to);
    int left [N];
    int id;
    exp_t e;
    bit done;
    for (int i = 0; i < N; i++) left[i] = drv_n[i];
    forever begin
      id = -1;
      for (int k = 0; k < N; k++)
        if (id < 0 && left[(mdl_ptr + k) % N] > 0) id = (mdl_ptr + k) % N;
      if (id < 0) break;
      e.id  = IDW'(id);
      e.res = expect_to ? QNAN_EXP : core_fn(drv_ang[id][drv_n[id] - left[id]]);
      e.err = expect_to;
      sb.push_back(e);
      left[id]--;
      mdl_ptr = (id + 1) % N;
    end
    @(negedge clk);
    core_lat  = lat;
    core_hang = expect_to;
    for (int i = 0; i < N; i++) begin
      drv_i[i] = 0;
      if (drv_n[i] > 0) begin
        req_angle[i*W +: W] = drv_ang[i][0];
        req_valid[i] = 1'b1;
      end
    end
    phase_t0 = cyc;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (req_valid == '0 && sb.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      check("phase_complete", 0, 1);
      sb.delete();
      req_valid = '0;
    end
  endtask

  initial begin : main
    logic [W-1:0] a6;
    int s0;
    int tot;
    int rs0;
    rst = 1'b0;
    req_valid = '0;
    req_angle = '0;
    clear_drv();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_busy", busy, 0);
    check("rst_core_clk_en", core_clk_en, 0);
    check("rst_core_angle", core_angle, 0);
    rst = 1'b0;

    // single request, sin(1.0)
    clear_drv();
    drv_n[1] = 1; drv_ang[1][0] = 32'h3F80_0000;
    s0 = core_starts;
    run_phase(12, 1'b0);
    check("single_latency", last_resp_cyc - phase_t0, 14);
    check("single_starts", core_starts - s0, 1);

    // bring pointer to 0, then continuous requesting: 0,1,2,3,0,1
    clear_drv();
    drv_n[3] = 1; drv_ang[3][0] = $urandom;
    run_phase(3, 1'b0);
    clear_drv();
    for (int i = 0; i < N; i++) begin
      drv_n[i] = (i < 2) ? 2 : 1;
      drv_ang[i][0] = $urandom;
      drv_ang[i][1] = $urandom;
    end
    s0 = core_starts;
    run_phase(5, 1'b0);
    check("cont_starts", core_starts - s0, 6);

    // serve 0, then 4'b1001 must go 3 before 0
    clear_drv();
    drv_n[0] = 1; drv_ang[0][0] = $urandom;
    run_phase(2, 1'b0);
    clear_drv();
    drv_n[0] = 1; drv_ang[0][0] = $urandom;
    drv_n[3] = 1; drv_ang[3][0] = $urandom;
    run_phase(4, 1'b0);

    for (int r = 0; r < 6; r++) begin
      clear_drv();
      tot = 0;
      for (int i = 0; i < N; i++) begin
        drv_n[i] = $urandom_range(0, 2);
        drv_ang[i][0] = $urandom;
        drv_ang[i][1] = $urandom;
        tot += drv_n[i];
      end
      if (tot == 0) begin
        drv_n[r % N] = 1;
        tot = 1;
      end
      s0 = core_starts;
      run_phase($urandom_range(1, 15), 1'b0);
      check("rand_starts", core_starts - s0, tot);
    end

    // angle changed mid-job must not reach the core
    clear_drv();
    a6 = $urandom;
    drv_n[2] = 1; drv_ang[2][0] = a6;
    fork
      run_phase(10, 1'b0);
      begin
        repeat (5) @(negedge clk);
        req_angle[2*W +: W] = ~a6;
      end
    join
    check("core_angle_held", core_angle, a6);

`ifdef CORDIC_ARB_TIMEOUT_EN
    clear_drv();
    drv_n[0] = 1; drv_ang[0][0] = $urandom;
    run_phase(1, 1'b1);
    check("timeout_latency", last_resp_cyc - phase_t0, 22);
    clear_drv();
    drv_n[1] = 1; drv_ang[1][0] = $urandom;
    run_phase(TO, 1'b0);
    check("done_at_timeout_latency", last_resp_cyc - phase_t0, 22);
`else
    clear_drv();
    drv_n[0] = 1; drv_ang[0][0] = $urandom;
    run_phase(2 * TO, 1'b0);
    check("long_wait_latency", last_resp_cyc - phase_t0, 2 + 2 * TO);
`endif

    // reset during WAIT; late core_done must be ignored
    clear_drv();
    @(negedge clk);
    core_lat = 8; core_hang = 1'b0;
    req_angle[1*W +: W] = $urandom;
    req_valid = 4'b0010;
    rs0 = resp_seen;
    repeat (4) @(negedge clk);
    check("busy_in_wait", busy, 1);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_core_angle", core_angle, 0);
    check("midrst_resp_result", resp_result, 0);
    @(negedge clk);
    rst = 1'b0;
    mdl_ptr = 0;
    repeat (8) @(negedge clk);
    check("midrst_no_resp", resp_seen - rs0, 0);
    check("midrst_idle_busy", busy, 0);

    clear_drv();
    for (int i = 0; i < N; i++) begin
      drv_n[i] = 1;
      drv_ang[i][0] = $urandom;
    end
    run_phase(3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
